result_bus_arbiter: RTL

RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

---
 rtl/result_bus_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/result_bus_arbiter.sv
// Result bus arbiter: per-unit result FIFOs drained one entry per cycle
// onto a single round-robin broadcast bus to the reservation stations.
module result_bus_arbiter #(
  parameter int UNITS         = 4,
  parameter int OPERAND_WIDTH = 32,
  parameter int RS_ID_WIDTH   = 5,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [UNITS-1:0]         result_valid,
  output logic [UNITS-1:0]         result_ready,
  input  logic [RS_ID_WIDTH-1:0]   result_rs_id [UNITS],
  input  logic [OPERAND_WIDTH-1:0] result_value [UNITS],
  output logic                     bus_valid,
  output logic [RS_ID_WIDTH-1:0]   bus_rs_id,
  output logic [OPERAND_WIDTH-1:0] bus_value
);

  localparam int UW = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = RS_ID_WIDTH + OPERAND_WIDTH;

  typedef logic [EW-1:0] ent_t;

  ent_t mem_q [UNITS][FIFO_DEPTH];

  logic [PW-1:0] wr_q  [UNITS];
  logic [PW-1:0] wr_d  [UNITS];
  logic [PW-1:0] rd_q  [UNITS];
  logic [PW-1:0] rd_d  [UNITS];
  logic [CW-1:0] cnt_q [UNITS];
  logic [CW-1:0] cnt_d [UNITS];

  logic [UNITS-1:0] rdy_q;
  logic [UNITS-1:0] rdy_d;
  logic [UNITS-1:0] push;
  logic [UNITS-1:0] pop;

  logic [UW-1:0] rr_q;
  logic [UW-1:0] rr_d;
  logic [UW-1:0] gnt_idx;
  logic          gnt_vld;
  int            k;

  logic                     bv_q;
  logic                     bv_d;
  logic [RS_ID_WIDTH-1:0]   brs_q;
  logic [RS_ID_WIDTH-1:0]   brs_d;
  logic [OPERAND_WIDTH-1:0] bval_q;
  logic [OPERAND_WIDTH-1:0] bval_d;

  ent_t head;

  // Scan downward so the lowest offset from rr_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    k       = 0;
    for (int i = UNITS - 1; i >= 0; i--) begin
      k = (int'(rr_q) + i) % UNITS;
      if (cnt_q[k] != '0) begin
        gnt_vld = 1'b1;
        gnt_idx = UW'(k);
      end
    end
  end

  assign head = mem_q[gnt_idx][rd_q[gnt_idx]];

  always_comb begin
    push = result_valid & rdy_q & {UNITS{~flush}};
    pop  = '0;
    if (gnt_vld && !flush) begin
      pop[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    for (int u = 0; u < UNITS; u++) begin
      wr_d[u] = wr_q[u] + PW'(push[u]);
      rd_d[u] = rd_q[u] + PW'(pop[u]);
      unique case ({push[u], pop[u]})
        2'b10:   cnt_d[u] = cnt_q[u] + CW'(1);
        2'b01:   cnt_d[u] = cnt_q[u] - CW'(1);
        default: cnt_d[u] = cnt_q[u];
      endcase
      if (flush) begin
        wr_d[u]  = '0;
        rd_d[u]  = '0;
        cnt_d[u] = '0;
      end
      rdy_d[u] = cnt_d[u] < CW'(FIFO_DEPTH);
    end
  end

  always_comb begin
    bv_d   = gnt_vld & ~flush;
    brs_d  = brs_q;
    bval_d = bval_q;
    rr_d   = rr_q;
    if (flush) begin
      rr_d = '0;
    end else if (gnt_vld) begin
      brs_d  = head[EW-1:OPERAND_WIDTH];
      bval_d = head[OPERAND_WIDTH-1:0];
      rr_d   = (gnt_idx == UW'(UNITS - 1)) ? '0
                                           : gnt_idx + UW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q   <= '0;
      bv_q   <= 1'b0;
      brs_q  <= '0;
      bval_q <= '0;
      rdy_q  <= '0;
      for (int u = 0; u < UNITS; u++) begin
        wr_q[u]  <= '0;
        rd_q[u]  <= '0;
        cnt_q[u] <= '0;
      end
    end else begin
      rr_q   <= rr_d;
      bv_q   <= bv_d;
      brs_q  <= brs_d;
      bval_q <= bval_d;
      rdy_q  <= rdy_d;
      for (int u = 0; u < UNITS; u++) begin
        wr_q[u]  <= wr_d[u];
        rd_q[u]  <= rd_d[u];
        cnt_q[u] <= cnt_d[u];
      end
    end
  end

  // Payload storage needs no reset; occupancy lives in cnt_q.
  always_ff @(posedge clk) begin
    for (int u = 0; u < UNITS; u++) begin
      if (push[u]) begin
        mem_q[u][wr_q[u]] <= {result_rs_id[u], result_value[u]};
      end
    end
  end

  assign result_ready = rdy_q;
  assign bus_valid    = bv_q;
  assign bus_rs_id    = brs_q;
  assign bus_value    = bval_q;

endmodule
